// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clock-divider controller.
package clk_div_pkg;

    // Default width of the divide ratio and the period counter.
    localparam int CNT_W_DEF = 8;

    // Smallest divide ratio that still produces a high and a low phase.
    localparam int MIN_DIV = 2;

    // Controller states: stopped, dividing, dividing with a request queued.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

endpackage

// File: rtl/div_counter.sv
// Period counter: counts 0..ratio-1 and wraps. A ratio of 0 freezes it.
// last marks the final cycle of a period; high is the first ceil(ratio/2) cycles.
module div_counter
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] ratio,
    output logic [CNT_W-1:0] count,
    output logic             last,
    output logic             high
);

    logic             running;
    logic [CNT_W:0]   ratio_ext;
    logic [CNT_W:0]   half;

    // One extra bit so ratio+1 cannot overflow at the top of the range.
    assign ratio_ext = {1'b0, ratio};
    assign half      = (ratio_ext + 1'b1) >> 1;
    assign running   = (ratio != '0);
    assign last      = running && (count == ratio - 1'b1);
    assign high      = running && ({1'b0, count} < half);

    // Advance the count each cycle; load restarts a period at 0.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            count <= '0;
        end else if (running) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock-divider controller: handshake, state machine and the queued request.
// Handshake: a request transfers on any rising edge where i_cfg_valid and
// o_cfg_ready are both 1; o_cfg_ready is low only while a request is queued.
// Reconfiguration and stop always land on a period boundary.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic             i_cfg_en,
    input  logic [CNT_W-1:0] i_cfg_div,
    output logic             o_clk_div,
    output logic             o_tick,
    output logic             o_active,
    output logic [CNT_W-1:0] o_cur_div,
    output logic             o_cfg_err
);

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cur_q, cur_nxt;
    logic             pend_en_q, pend_en_nxt;
    logic [CNT_W-1:0] pend_div_q, pend_div_nxt;
    logic             err_q, err_nxt;
    logic             load;
    logic             accept;
    logic             bad_req;
    logic [CNT_W-1:0] count;
    logic             last;
    logic             high;

    assign o_cfg_ready = (state_q != PEND);
    assign accept      = i_cfg_valid && o_cfg_ready;
    assign bad_req     = i_cfg_en && (i_cfg_div < CNT_W'(MIN_DIV));

    div_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (i_clk),
        .rst   (i_rst),
        .load  (load),
        .ratio (cur_q),
        .count (count),
        .last  (last),
        .high  (high)
    );

    // Next-state logic: rejects illegal runs, queues mid-period requests and
    // applies a request (direct or queued) only on the last cycle of a period.
    always_comb begin
        state_nxt    = state_q;
        cur_nxt      = cur_q;
        pend_en_nxt  = pend_en_q;
        pend_div_nxt = pend_div_q;
        err_nxt      = 1'b0;
        load         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bad_req) begin
                        err_nxt = 1'b1;
                    end else if (i_cfg_en) begin
                        state_nxt = RUN;
                        cur_nxt   = i_cfg_div;
                        load      = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    if (bad_req) begin
                        err_nxt = 1'b1;
                    end else if (last) begin
                        load      = 1'b1;
                        state_nxt = i_cfg_en ? RUN : IDLE;
                        cur_nxt   = i_cfg_en ? i_cfg_div : '0;
                    end else begin
                        state_nxt    = PEND;
                        pend_en_nxt  = i_cfg_en;
                        pend_div_nxt = i_cfg_div;
                    end
                end
            end
            PEND: begin
                if (last) begin
                    load         = 1'b1;
                    state_nxt    = pend_en_q ? RUN : IDLE;
                    cur_nxt      = pend_en_q ? pend_div_q : '0;
                    pend_en_nxt  = 1'b0;
                    pend_div_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cur_nxt   = '0;
                load      = 1'b1;
            end
        endcase
    end

    // State, ratio, queued request and error pulse registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            pend_en_q  <= 1'b0;
            pend_div_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            cur_q      <= cur_nxt;
            pend_en_q  <= pend_en_nxt;
            pend_div_q <= pend_div_nxt;
            err_q      <= err_nxt;
        end
    end

    // Outputs come from registers only; cur_q is 0 in IDLE so high is 0 there.
    assign o_active  = (state_q != IDLE);
    assign o_tick    = o_active && (count == '0);
    assign o_clk_div = high;
    assign o_cur_div = cur_q;
    assign o_cfg_err = err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl with hand-computed expectations.
module tb_clk_div_ctrl;

    localparam int CNT_W = 8;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_cfg_valid = 1'b0;
    logic             o_cfg_ready;
    logic             i_cfg_en = 1'b0;
    logic [CNT_W-1:0] i_cfg_div = '0;
    logic             o_clk_div;
    logic             o_tick;
    logic             o_active;
    logic [CNT_W-1:0] o_cur_div;
    logic             o_cfg_err;

    int n_checks = 0;
    int n_errors = 0;

    clk_div_ctrl #(.CNT_W(CNT_W)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_cfg_valid (i_cfg_valid),
        .o_cfg_ready (o_cfg_ready),
        .i_cfg_en    (i_cfg_en),
        .i_cfg_div   (i_cfg_div),
        .o_clk_div   (o_clk_div),
        .o_tick      (o_tick),
        .o_active    (o_active),
        .o_cur_div   (o_cur_div),
        .o_cfg_err   (o_cfg_err)
    );

    // Clock generation.
    always #5 i_clk = ~i_clk;

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Present a request for exactly one accepting edge.
    task automatic request(input logic en, input logic [CNT_W-1:0] div);
        i_cfg_valid = 1'b1;
        i_cfg_en    = en;
        i_cfg_div   = div;
        step();
        i_cfg_valid = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_clk"},    32'(o_clk_div), 32'd0);
        chk({tag, "_tick"},   32'(o_tick),    32'd0);
        chk({tag, "_active"}, 32'(o_active),  32'd0);
        chk({tag, "_cur"},    32'(o_cur_div), 32'd0);
        chk({tag, "_err"},    32'(o_cfg_err), 32'd0);
        chk({tag, "_ready"},  32'(o_cfg_ready), 32'd1);
    endtask

    initial begin
        // Reset for two cycles.
        i_rst = 1'b1;
        step();
        step();
        i_rst = 1'b0;
        chk_idle("reset");

        // N=4: first tick right after acceptance, pattern 1100.
        request(1'b1, 8'd4);
        for (int i = 0; i < 8; i++) begin
            chk("n4_tick", 32'(o_tick),    32'((i % 4) == 0));
            chk("n4_clk",  32'(o_clk_div), 32'((i % 4) < 2));
            chk("n4_cur",  32'(o_cur_div), 32'd4);
            chk("n4_act",  32'(o_active),  32'd1);
            step();
        end

        // Stop at counter=3: idle on the next cycle, no extra tick.
        step();
        step();
        step();
        chk("stop_ready", 32'(o_cfg_ready), 32'd1);
        request(1'b0, 8'd0);
        chk_idle("stop");
        step();
        chk("stop_tick2", 32'(o_tick), 32'd0);

        // Illegal N=1 from idle: one-cycle error, stays idle.
        request(1'b1, 8'd1);
        chk("n1_err",    32'(o_cfg_err), 32'd1);
        chk("n1_active", 32'(o_active),  32'd0);
        chk("n1_cur",    32'(o_cur_div), 32'd0);
        step();
        chk("n1_err_off", 32'(o_cfg_err), 32'd0);
        chk("n1_active2", 32'(o_active),  32'd0);

        // N=5: pattern 11100.
        request(1'b1, 8'd5);
        for (int i = 0; i < 10; i++) begin
            chk("n5_tick", 32'(o_tick),    32'((i % 5) == 0));
            chk("n5_clk",  32'(o_clk_div), 32'((i % 5) < 3));
            chk("n5_cur",  32'(o_cur_div), 32'd5);
            step();
        end

        // Switch to N=6 at counter=0: queued until the N=5 period ends.
        request(1'b1, 8'd6);
        for (int c = 1; c < 5; c++) begin
            chk("to6_ready", 32'(o_cfg_ready), 32'd0);
            chk("to6_cur",   32'(o_cur_div),   32'd5);
            chk("to6_clk",   32'(o_clk_div),   32'(c < 3));
            step();
        end
        chk("n6_cur",   32'(o_cur_div),   32'd6);
        chk("n6_tick",  32'(o_tick),      32'd1);
        chk("n6_ready", 32'(o_cfg_ready), 32'd1);
        step();
        chk("n6_c1_tick", 32'(o_tick),    32'd0);
        chk("n6_c1_clk",  32'(o_clk_div), 32'd1);

        // Request N=3 at counter=1: the 6-cycle period completes first.
        request(1'b1, 8'd3);
        for (int c = 2; c < 6; c++) begin
            chk("to3_ready", 32'(o_cfg_ready), 32'd0);
            chk("to3_clk",   32'(o_clk_div),   32'(c < 3));
            chk("to3_tick",  32'(o_tick),      32'd0);
            chk("to3_cur",   32'(o_cur_div),   32'd6);
            step();
        end
        for (int i = 0; i < 6; i++) begin
            chk("n3_tick",  32'(o_tick),      32'((i % 3) == 0));
            chk("n3_clk",   32'(o_clk_div),   32'((i % 3) < 2));
            chk("n3_cur",   32'(o_cur_div),   32'd3);
            chk("n3_ready", 32'(o_cfg_ready), 32'd1);
            step();
        end

        // Queue N=8, then a one-cycle reset drops it.
        request(1'b1, 8'd8);
        chk("pend_ready", 32'(o_cfg_ready), 32'd0);
        chk("pend_act",   32'(o_active),    32'd1);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk_idle("pend_rst");
        for (int i = 0; i < 5; i++) begin
            step();
            chk("pend_drop_act", 32'(o_active),  32'd0);
            chk("pend_drop_cur", 32'(o_cur_div), 32'd0);
        end

        // Request on the last cycle of a period applies without queueing.
        request(1'b1, 8'd4);
        step();
        step();
        step();
        chk("direct_ready", 32'(o_cfg_ready), 32'd1);
        request(1'b1, 8'd2);
        chk("direct_cur",   32'(o_cur_div),   32'd2);
        chk("direct_tick",  32'(o_tick),      32'd1);
        chk("direct_clk",   32'(o_clk_div),   32'd1);
        chk("direct_ready2", 32'(o_cfg_ready), 32'd1);
        step();
        chk("n2_c1_tick", 32'(o_tick),    32'd0);
        chk("n2_c1_clk",  32'(o_clk_div), 32'd0);
        step();
        chk("n2_c0_tick", 32'(o_tick),    32'd1);

        // Illegal request while running: error pulse, ratio unchanged.
        request(1'b1, 8'd0);
        chk("run_err",   32'(o_cfg_err),   32'd1);
        chk("run_cur",   32'(o_cur_div),   32'd2);
        chk("run_ready", 32'(o_cfg_ready), 32'd1);
        chk("run_act",   32'(o_active),    32'd1);

        // A request during reset is ignored.
        i_rst = 1'b1;
        request(1'b1, 8'd4);
        i_rst = 1'b0;
        chk_idle("rst_req");
        step();
        chk("rst_req_act", 32'(o_active), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter CNT_W, default 8: width of the divide ratio and period counter.
REQ-002 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 i_rst  input  1  synchronous, active-high reset.
REQ-004 i_cfg_valid  input  1  configuration request valid.
REQ-005 o_cfg_ready  output  1  controller can accept a request this cycle.
REQ-006 i_cfg_en  input  1  requested state: 1 = run, 0 = stop.
REQ-007 i_cfg_div  input  CNT_W  requested divide ratio N; legal range 2..2^CNT_W-1.
REQ-008 o_clk_div  output  1  divided waveform, qualified by i_clk; not a clock net.
REQ-009 o_tick  output  1  one-cycle pulse on the first cycle of every output period.
REQ-010 o_active  output  1  high while in RUN or PEND.
REQ-011 o_cur_div  output  CNT_W  ratio currently in effect; 0 in IDLE.
REQ-012 o_cfg_err  output  1  one-cycle pulse when a request is rejected.

Function
REQ-013 A request SHALL be accepted when i_cfg_valid && o_cfg_ready; o_cfg_ready SHALL be 1 in IDLE and RUN and 0 in PEND.
REQ-014 An accepted request with i_cfg_en=1 and i_cfg_div<2 SHALL be rejected: o_cfg_err=1 on the next cycle, with no state change.
REQ-015 States SHALL be IDLE, RUN and PEND.
REQ-016 IDLE: outputs o_clk_div=0, o_tick=0 and o_cur_div=0; the period counter SHALL hold 0.
REQ-017 IDLE, legal run request accepted in cycle T: the controller SHALL enter RUN at T+1 with the counter at 0 and o_cur_div=N.
REQ-018 IDLE, stop request: accepted and ignored.
REQ-019 RUN: the counter SHALL count 0..o_cur_div-1, then wrap to 0.
REQ-020 RUN: o_tick=1 exactly when the counter is 0.
REQ-021 RUN: o_clk_div=1 when the counter is < ceil(N/2), else 0. Even N gives N/2 high and N/2 low; odd N gives (N+1)/2 high and (N-1)/2 low.
REQ-022 All outputs SHALL be decoded from registered state only, with no combinational path from any input.
REQ-023 RUN, request accepted in a cycle where counter != N-1: the request SHALL be stored and the controller SHALL enter PEND. The current period SHALL complete unchanged.
REQ-024 RUN, request accepted in the cycle where counter == N-1: the request SHALL take effect at that period boundary directly, without entering PEND.
REQ-025 PEND, at the cycle where counter == N-1:
- stored run request: load the new N, reset the counter to 0, return to RUN.
- stored stop request: go to IDLE.
REQ-026 A boundary-applied stop SHALL cause a cycle with o_clk_div=0 and o_tick=0 to follow the last period immediately; no truncated period SHALL ever be emitted.
REQ-027 A run request with N equal to the current ratio SHALL still be treated as a reconfiguration; the phase is unchanged because it applies at the boundary.
REQ-028 The counter SHALL never exceed o_cur_div-1; a ratio change takes effect only at a boundary, so no wrap hazard exists.

Reset
REQ-029 While i_rst=1, the state SHALL become IDLE and the counter and stored request SHALL clear.
REQ-030 During reset, all outputs SHALL be 0 except o_cfg_ready.
REQ-031 o_cfg_ready SHALL be 1 from the first cycle after i_rst deasserts.
REQ-032 Reset asserted mid-period or in PEND SHALL abort immediately; the pending request SHALL be discarded.
REQ-033 A request presented in the same cycle as i_rst=1 SHALL be ignored.

Structure
REQ-034 A shared package clk_div_pkg SHALL hold:
- the state enum typedef {IDLE, RUN, PEND};
- the constant MIN_DIV=2;
- the default CNT_W.
REQ-035 One sub-module, div_counter, SHALL implement the period counter. Its ports SHALL be load, ratio, count, last and high.
REQ-036 The FSM, handshake and pending-request register SHALL reside in clk_div_ctrl.

Verification
REQ-037 Reset for 2 cycles, then a run request with N=4:
- o_tick SHALL pulse every 4 cycles;
- o_clk_div SHALL follow the pattern 1100;
- the first tick SHALL occur on the cycle after acceptance.
REQ-038 Run request with N=5: o_clk_div SHALL follow the pattern 11100, repeating; o_cur_div SHALL equal 5.
REQ-039 Running at N=6, request N=3 at counter=1:
- o_cfg_ready=0 until the boundary;
- periods SHALL be 6 cycles, then 3-cycle periods of pattern 110.
REQ-040 Running at N=4, stop request at counter=3: IDLE SHALL be reached on the next cycle, with no extra tick and o_active=0.
REQ-041 Run request with N=1 from IDLE: o_cfg_err SHALL pulse for 1 cycle and the controller SHALL stay in IDLE.
REQ-042 In PEND with N=8, assert i_rst for 1 cycle: all outputs SHALL be 0 and the pending request SHALL be dropped.
